// File: rtl/alu_ctrl.sv
// Sequencer for an external ALU: accepts one request, runs one EXEC cycle, holds the response.
// Define COND_EXEC_EN to gate execution on the condition code; otherwise every valid op executes.
module alu_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [3:0]   in_cond,
  input  logic         in_setflags,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_cntr,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [3:0]   out_flags,
  output logic         out_executed,
  output logic         out_err
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t       state, state_nxt;
  logic [2:0]   op_q;
  logic         setf_q;
  logic [N-1:0] a_q, b_q;
  logic [3:0]   flags_q;
  logic         accept, op_ok, pass, run;

`ifdef COND_EXEC_EN
  logic [3:0] cond_q;

  // Flag order is {V, N, C, Z}.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic z, c, n, v;
    z = f[0]; c = f[1]; n = f[2]; v = f[3];
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = !c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = c && !z;
      4'b1001: cond_pass = !c || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      default: cond_pass = 1'b1;
    endcase
  endfunction

  assign pass = cond_pass(cond_q, flags_q);
`else
  logic unused_cond;
  assign unused_cond = ^in_cond;
  assign pass        = 1'b1;
`endif

  assign accept = in_valid && (state == IDLE);
  assign op_ok  = !(op_q[2] && op_q[1]);
  assign run    = op_ok && pass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output gets a default before the case so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_cntr  = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = EXEC;
      end
      EXEC: begin
        alu_a     = a_q;
        alu_b     = b_q;
        alu_cntr  = op_q;
        state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      setf_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      flags_q      <= '0;
      out_result   <= '0;
      out_executed <= 1'b0;
      out_err      <= 1'b0;
`ifdef COND_EXEC_EN
      cond_q       <= '0;
`endif
    end else begin
      if (accept) begin
        op_q   <= in_op;
        setf_q <= in_setflags;
        a_q    <= in_a;
        b_q    <= in_b;
`ifdef COND_EXEC_EN
        cond_q <= in_cond;
`endif
      end
      if (state == EXEC) begin
        out_result   <= run ? alu_result : '0;
        out_executed <= run;
        out_err      <= !op_ok;
        if (run && setf_q) flags_q <= alu_flags;
      end
    end
  end

  assign out_flags = flags_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed self-checking bench for alu_ctrl (N=8) with a behavioural model of the external ALU.
// Expectations adapt to whether COND_EXEC_EN is defined.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [2:0] in_op;
  logic [3:0] in_cond;
  logic       in_setflags;
  logic [7:0] in_a, in_b;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_cntr;
  logic [7:0] alu_result;
  logic [3:0] alu_flags;
  logic       out_valid, out_ready;
  logic [7:0] out_result;
  logic [3:0] out_flags;
  logic       out_executed, out_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_ctrl #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_cond(in_cond), .in_setflags(in_setflags),
    .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cntr(alu_cntr),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .out_executed(out_executed), .out_err(out_err)
  );

  // External ALU: flags {V,N,C,Z}; SUB carry means no borrow.
  logic [8:0] m_sum;
  logic       m_c, m_v;
  always_comb begin
    m_sum = '0;
    m_c   = 1'b0;
    m_v   = 1'b0;
    case (alu_cntr)
      3'b000: begin
        m_sum = {1'b0, alu_a} + {1'b0, alu_b};
        m_c   = m_sum[8];
        m_v   = (alu_a[7] == alu_b[7]) && (m_sum[7] != alu_a[7]);
      end
      3'b001: begin
        m_sum = {1'b0, alu_a} - {1'b0, alu_b};
        m_c   = ~m_sum[8];
        m_v   = (alu_a[7] != alu_b[7]) && (m_sum[7] != alu_a[7]);
      end
      3'b010:  m_sum = {1'b0, alu_a & alu_b};
      3'b011:  m_sum = {1'b0, alu_a | alu_b};
      3'b100:  m_sum = {1'b0, ~alu_b};
      3'b101:  m_sum = {1'b0, alu_b};
      default: m_sum = '0;
    endcase
    alu_result = m_sum[7:0];
    alu_flags  = {m_v, m_sum[7], m_c, (m_sum[7:0] == 8'h00)};
  end

  // Presents a request in IDLE; returns 1 ns after the accepting edge (DUT now in EXEC).
  task automatic send(input logic [2:0] op, input logic [3:0] cond, input logic sf,
                      input logic [7:0] a, input logic [7:0] b);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL send_in_ready got %b want 1", in_ready);
    end
    in_op = op; in_cond = cond; in_setflags = sf; in_a = a; in_b = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic release_resp(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_release got valid=%b ready=%b want valid=0 ready=1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_cond = '0; in_setflags = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hs got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    checks++;
    if (out_result !== 8'h00 || out_flags !== 4'b0000 || out_executed !== 1'b0 || out_err !== 1'b0) begin
      errors++; $display("FAIL reset_out got res=%h flags=%b ex=%b err=%b want 00 0000 0 0",
                         out_result, out_flags, out_executed, out_err);
    end
    checks++;
    if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_cntr !== 3'b000) begin
      errors++; $display("FAIL reset_alu got a=%h b=%h cntr=%b want 0", alu_a, alu_b, alu_cntr);
    end
  endtask

  task automatic test_add;
    send(3'b000, 4'b1110, 1'b1, 8'h7F, 8'h01);
    checks++;
    if (alu_a !== 8'h7F || alu_b !== 8'h01 || alu_cntr !== 3'b000 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL add_exec got a=%h b=%h cntr=%b valid=%b ready=%b want 7f 01 000 0 0",
                         alu_a, alu_b, alu_cntr, out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 8'h80 || out_flags !== 4'b1100 || out_executed !== 1'b1 || out_err !== 1'b0) begin
      errors++; $display("FAIL add_resp got v=%b res=%h flags=%b ex=%b err=%b want 1 80 1100 1 0",
                         out_valid, out_result, out_flags, out_executed, out_err);
    end
    checks++;
    if (alu_cntr !== 3'b000 || alu_a !== 8'h00) begin
      errors++; $display("FAIL add_alu_idle got a=%h cntr=%b want 00 000", alu_a, alu_cntr);
    end
    release_resp("add");
  endtask

  task automatic test_sub_mov;
    send(3'b001, 4'b1110, 1'b1, 8'h05, 8'h05);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 8'h00 || out_flags !== 4'b0011 || out_executed !== 1'b1) begin
      errors++; $display("FAIL sub_resp got v=%b res=%h flags=%b ex=%b want 1 00 0011 1",
                         out_valid, out_result, out_flags, out_executed);
    end
    release_resp("sub");
    send(3'b101, 4'b0000, 1'b0, 8'h12, 8'hAA);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 8'hAA || out_flags !== 4'b0011 || out_executed !== 1'b1 || out_err !== 1'b0) begin
      errors++; $display("FAIL mov_resp got v=%b res=%h flags=%b ex=%b err=%b want 1 aa 0011 1 0",
                         out_valid, out_result, out_flags, out_executed, out_err);
    end
    release_resp("mov");
  endtask

  // Flags are {V,N,C,Z} = 0011 throughout; MOV with setflags low.
  task automatic test_cond;
    logic [3:0] conds [9] = '{4'b0001, 4'b1000, 4'b1001, 4'b1010, 4'b1011,
                              4'b1100, 4'b1101, 4'b0010, 4'b0100};
    logic       want_c [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      logic [7:0] b, want_res;
      logic       want_ex;
      b = 8'h55 + 8'(i);
`ifdef COND_EXEC_EN
      want_ex = want_c[i];
`else
      want_ex = 1'b1;
`endif
      want_res = want_ex ? b : 8'h00;
      send(3'b101, conds[i], 1'b0, 8'h00, b);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_executed !== want_ex || out_result !== want_res || out_flags !== 4'b0011 || out_err !== 1'b0) begin
        errors++; $display("FAIL cond_%b got v=%b ex=%b res=%h flags=%b err=%b want 1 %b %h 0011 0",
                           conds[i], out_valid, out_executed, out_result, out_flags, out_err, want_ex, want_res);
      end
      release_resp("cond");
    end
  endtask

  task automatic test_err;
    send(3'b110, 4'b1110, 1'b1, 8'h01, 8'h02);
    checks++;
    if (alu_cntr !== 3'b110 || alu_a !== 8'h01 || alu_b !== 8'h02) begin
      errors++; $display("FAIL err_exec got a=%h b=%h cntr=%b want 01 02 110", alu_a, alu_b, alu_cntr);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || out_executed !== 1'b0 || out_result !== 8'h00 || out_flags !== 4'b0011) begin
      errors++; $display("FAIL err_resp got v=%b err=%b ex=%b res=%h flags=%b want 1 1 0 00 0011",
                         out_valid, out_err, out_executed, out_result, out_flags);
    end
    release_resp("err");
  endtask

  task automatic test_hold;
    send(3'b000, 4'b1110, 1'b0, 8'h03, 8'h04);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      in_op = 3'b011; in_a = 8'hF0; in_b = 8'h0F;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 8'h07 || out_executed !== 1'b1 ||
          out_err !== 1'b0 || out_flags !== 4'b0011 || alu_cntr !== 3'b000 || alu_a !== 8'h00) begin
        errors++; $display("FAIL hold_%0d got v=%b rdy=%b res=%h ex=%b err=%b flags=%b alu_a=%h want 1 0 07 1 0 0011 00",
                           i, out_valid, in_ready, out_result, out_executed, out_err, out_flags, alu_a);
      end
    end
    in_valid = 1'b0;
    release_resp("hold");
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_a !== 8'h00) begin
      errors++; $display("FAIL hold_no_capture got v=%b rdy=%b alu_a=%h want 0 1 00", out_valid, in_ready, alu_a);
    end
  endtask

  task automatic test_back_to_back;
    send(3'b010, 4'b1110, 1'b0, 8'h3C, 8'h0F);
    @(posedge clk); #1;
    release_resp("b2b_first");
    send(3'b100, 4'b1110, 1'b0, 8'h00, 8'h0F);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 8'hF0 || out_executed !== 1'b1) begin
      errors++; $display("FAIL b2b_not got v=%b res=%h ex=%b want 1 f0 1", out_valid, out_result, out_executed);
    end
    release_resp("b2b_second");
  endtask

  task automatic test_reset_exec;
    send(3'b000, 4'b1110, 1'b1, 8'h7F, 8'h01);
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_flags !== 4'b0000 || alu_cntr !== 3'b000 || alu_a !== 8'h00) begin
      errors++; $display("FAIL rst_async got rdy=%b v=%b flags=%b alu_a=%h want 1 0 0000 00",
                         in_ready, out_valid, out_flags, alu_a);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_flags !== 4'b0000 || out_result !== 8'h00) begin
        errors++; $display("FAIL rst_after_%0d got v=%b rdy=%b flags=%b res=%h want 0 1 0000 00",
                           i, out_valid, in_ready, out_flags, out_result);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_mov();
    test_cond();
    test_err();
    test_hold();
    test_back_to_back();
    test_reset_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter N, default 8, operand/result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  request accepted when in_valid and in_ready are both high at a clk edge.
REQ-006 in_op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT B, 101 MOV B, 110/111 unimplemented.
REQ-007 in_cond  input  4  condition code (see REQ-017).
REQ-008 in_setflags  input  1  update flag register on execution.
REQ-009 in_a, in_b  input  N  signed operands.
REQ-010 alu_a, alu_b  output  N  and alu_cntr  output  3  drive the external ALU.
REQ-011 alu_result  input  N  and alu_flags  input  4  come from the external ALU: bit0 Z, bit1 C, bit2 N, bit3 V.
REQ-012 out_valid  output  1  and out_ready  input  1  form the response handshake.
REQ-013 out_result  output  N, out_flags  output  4 (flag register, same bit order), out_executed  output  1, out_err  output  1.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC, HOLD; in_ready = 1 only in IDLE.
REQ-015 IDLE->EXEC on accept; in_op, in_cond, in_setflags, in_a, in_b are captured into internal registers.
REQ-016 In EXEC, alu_a/alu_b/alu_cntr SHALL equal the captured values; outside EXEC they SHALL be 0.
REQ-017 Condition pass: 0000 Z, 0001 !Z, 0010 C, 0011 !C, 0100 N, 0101 !N, 0110 V, 0111 !V, 1000 C&!Z, 1001 !C|Z, 1010 N==V, 1011 N!=V, 1100 !Z&(N==V), 1101 Z|(N!=V), 1110 and 1111 always. Evaluation uses the flag register value at the start of EXEC.
REQ-018 EXEC->HOLD unconditionally after one cycle; on that edge out_result, out_executed and out_err are registered and out_valid rises. Accept-to-out_valid latency is exactly 2 cycles.
REQ-019 Valid op, condition pass: out_result = alu_result; out_executed = 1; out_err = 0; flag register <= alu_flags if setflags, else unchanged.
REQ-020 Valid op, condition fail: out_result = 0; out_executed = 0; out_err = 0; flags unchanged.
REQ-021 Op 110/111 (regardless of condition): out_err = 1; out_executed = 0; out_result = 0; flags unchanged.
REQ-022 In HOLD, out_result, out_flags, out_executed and out_err SHALL stay stable until out_ready; HOLD->IDLE and out_valid falls on the edge where out_ready = 1.
REQ-023 in_valid in EXEC/HOLD SHALL be ignored (no capture, no loss of the held response).
REQ-024 No back-to-back overlap: at most one transaction is in flight; throughput is at most 1 per 3 cycles.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, flag register 4'b0000, out_valid 0, out_result 0, out_executed 0, out_err 0, in_ready 1.
REQ-026 Reset during EXEC or HOLD SHALL discard the transaction; no out_valid is produced for it after release.

Configuration
REQ-027 Macro COND_EXEC_EN defined: conditional execution per REQ-017.
REQ-028 COND_EXEC_EN undefined: in_cond is ignored and every valid op executes (condition always passes); all other behaviour is identical.

Verification (N=8, COND_EXEC_EN defined unless stated)
REQ-029 After reset, ADD 8'h7F+8'h01, setflags, cond 1110 -> 2 cycles after accept: out_valid, out_result 8'h80, out_flags 4'b1100, out_executed 1.
REQ-030 SUB 8'h05-8'h05 setflags -> out_result 8'h00, out_flags 4'b0011; then MOV B=8'hAA cond 0000 -> out_result 8'hAA, executed 1, flags still 4'b0011.
REQ-031 With Z=1, MOV B=8'h55 cond 0001 -> out_executed 0, out_result 0, flags unchanged; with COND_EXEC_EN undefined the same request gives executed 1, out_result 8'h55.
REQ-032 in_op 3'b110 -> out_err 1, out_executed 0, out_result 0, flags unchanged.
REQ-033 out_ready held low 5 cycles in HOLD while in_valid pulses -> outputs stable, in_ready 0, no second capture; out_ready high -> IDLE next cycle.
REQ-034 rst_n pulsed low during EXEC -> no out_valid afterwards, out_flags 4'b0000, in_ready 1.
